// File: rtl/maze_pkg.sv
// Shared constants, state encoding and helpers for the maze player controller.
package maze_pkg;

   // One-hot direction codes as delivered by the input debouncer
   localparam logic [3:0] UP    = 4'b0001;
   localparam logic [3:0] DOWN  = 4'b0010;
   localparam logic [3:0] RIGHT = 4'b0100;
   localparam logic [3:0] LEFT  = 4'b1000;

   // Maze RAM tile values
   localparam logic FLOOR = 1'b0;
   localparam logic WALL  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      CHECK,
      DONE
   } state_e;

   // True when exactly one bit of the direction word is set
   function automatic logic is_onehot(input logic [3:0] d);
      return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/maze_direction_sampler.sv
// Direction sampler: remembers last cycle's direction word and emits a
// one-cycle dir_valid for a fresh one-hot press while the controller is idle.
// Optional feature macro: MAZE_AUTO_REPEAT_EN (held direction re-fires every
// REPEAT_PERIOD idle cycles).
module maze_direction_sampler
   import maze_pkg::*;
#(
   parameter int unsigned REPEAT_PERIOD = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       idle_i,
   input  logic       restart_i,
   input  logic [3:0] dir_i,
   output logic       dir_valid_o,
   output logic [3:0] dir_code_o
);

   logic [3:0] prev_dir_q;
   logic       edge_hit;

   // Previous direction word, captured every cycle regardless of state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) prev_dir_q <= '0;
      else          prev_dir_q <= dir_i;
   end

   assign edge_hit   = (dir_i != prev_dir_q) && is_onehot(dir_i);
   assign dir_code_o = dir_i;

`ifdef MAZE_AUTO_REPEAT_EN
   localparam int unsigned TW = (REPEAT_PERIOD < 2) ? 1 : $clog2(REPEAT_PERIOD);

   logic [TW-1:0] rpt_q, rpt_d;
   logic          rpt_hit;

   // Repeat timer runs only while the same one-hot key is held in IDLE
   always_comb begin
      rpt_d   = rpt_q;
      rpt_hit = 1'b0;
      if (restart_i || !idle_i || (dir_i != prev_dir_q) || !is_onehot(dir_i)) begin
         rpt_d = '0;
      end else if (rpt_q == TW'(REPEAT_PERIOD - 1)) begin
         rpt_hit = 1'b1;
         rpt_d   = '0;
      end else begin
         rpt_d = rpt_q + 1'b1;
      end
   end

   // Repeat timer register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rpt_q <= '0;
      else          rpt_q <= rpt_d;
   end

   assign dir_valid_o = idle_i && !restart_i && (edge_hit || rpt_hit);
`else
   assign dir_valid_o = idle_i && !restart_i && edge_hit;
`endif

endmodule

// File: rtl/maze_player_controller.sv
// Maze player controller: accepts one-hot moves, reads the target tile from
// the maze RAM with a fixed read latency and commits the move on FLOOR.
// Optional feature macro: MAZE_AUTO_REPEAT_EN (see maze_direction_sampler).
module maze_player_controller
   import maze_pkg::*;
#(
   parameter int unsigned WIDTH         = 10,
   parameter int unsigned HEIGHT        = 10,
   parameter int unsigned ADDR_W        = 11,
   parameter int unsigned READ_LATENCY  = 2,
   parameter int unsigned START_X       = 0,
   parameter int unsigned START_Y       = 0,
   parameter int unsigned END_X         = WIDTH - 1,
   parameter int unsigned END_Y         = HEIGHT - 1,
   parameter int unsigned REPEAT_PERIOD = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [3:0]        player_direction,
   input  logic              at_start,
   input  logic              maze_read_data,
   output logic [ADDR_W-1:0] maze_read_address,
   output logic              maze_read_request,
   output logic [7:0]        player_x,
   output logic [7:0]        player_y,
   output logic              at_end,
   output logic              move_blocked,
   output logic [15:0]       move_count
);

   localparam logic [7:0] SX        = 8'(START_X);
   localparam logic [7:0] SY        = 8'(START_Y);
   localparam logic [7:0] EX        = 8'(END_X);
   localparam logic [7:0] EY        = 8'(END_Y);
   localparam logic [7:0] XMAX      = 8'(WIDTH - 1);
   localparam logic [7:0] YMAX      = 8'(HEIGHT - 1);
   localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);

   if ((READ_LATENCY < 1) || (READ_LATENCY > 7) || (REPEAT_PERIOD < 1) ||
       ((WIDTH * HEIGHT) > (1 << ADDR_W))) begin : g_bad_params
      $error("maze_player_controller: parameter out of range");
   end

   state_e            state_q, state_d;
   logic [7:0]        x_q, x_d, y_q, y_d;
   logic [7:0]        tx_q, tx_d, ty_q, ty_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        wait_q, wait_d;
   logic              blocked_q, blocked_d;
   logic [15:0]       count_q, count_d;

   logic              dir_valid;
   logic [3:0]        dir_code;
   logic [7:0]        nx, ny;
   logic              in_bounds;

   maze_direction_sampler #(
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_sampler (
      .clock       (clock),
      .reset_n     (reset_n),
      .idle_i      (state_q == IDLE),
      .restart_i   (at_start),
      .dir_i       (player_direction),
      .dir_valid_o (dir_valid),
      .dir_code_o  (dir_code)
   );

   // Neighbour tile for the requested direction and whether it lies inside the maze
   always_comb begin
      nx        = x_q;
      ny        = y_q;
      in_bounds = 1'b0;
      case (dir_code)
         UP:      begin ny = y_q - 8'd1; in_bounds = (y_q != 8'd0); end
         DOWN:    begin ny = y_q + 8'd1; in_bounds = (y_q != YMAX); end
         RIGHT:   begin nx = x_q + 8'd1; in_bounds = (x_q != XMAX); end
         LEFT:    begin nx = x_q - 8'd1; in_bounds = (x_q != 8'd0); end
         default: ;
      endcase
   end

   // Next-state logic; restart overrides every state and abandons any read in flight
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      tx_d      = tx_q;
      ty_d      = ty_q;
      addr_d    = addr_q;
      wait_d    = wait_q;
      blocked_d = 1'b0;
      count_d   = count_q;
      if (at_start) begin
         state_d = IDLE;
         x_d     = SX;
         y_d     = SY;
         count_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (dir_valid) begin
                  if (!in_bounds) begin
                     blocked_d = 1'b1;
                  end else begin
                     tx_d    = nx;
                     ty_d    = ny;
                     addr_d  = ADDR_W'(WIDTH) * ADDR_W'(ny) + ADDR_W'(nx);
                     state_d = REQ;
                  end
               end
            end
            REQ: begin
               wait_d  = WAIT_INIT;
               state_d = (READ_LATENCY == 1) ? CHECK : WAIT;
            end
            WAIT: begin
               wait_d = wait_q - 3'd1;
               if (wait_q == 3'd1) state_d = CHECK;
            end
            CHECK: begin
               if (maze_read_data == FLOOR) begin
                  x_d     = tx_q;
                  y_d     = ty_q;
                  count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                  state_d = ((tx_q == EX) && (ty_q == EY)) ? DONE : IDLE;
               end else begin
                  blocked_d = 1'b1;
                  state_d   = IDLE;
               end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         x_q       <= SX;
         y_q       <= SY;
         tx_q      <= '0;
         ty_q      <= '0;
         addr_q    <= '0;
         wait_q    <= '0;
         blocked_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         tx_q      <= tx_d;
         ty_q      <= ty_d;
         addr_q    <= addr_d;
         wait_q    <= wait_d;
         blocked_q <= blocked_d;
         count_q   <= count_d;
      end
   end

   assign maze_read_address = addr_q;
   assign maze_read_request = (state_q == REQ);
   assign player_x          = x_q;
   assign player_y          = y_q;
   assign at_end            = (state_q == DONE);
   assign move_blocked      = blocked_q;
   assign move_count        = count_q;

endmodule

// File: tb/tb_maze_player_controller.sv
// Bench for maze_player_controller: transaction-timed reference model of the
// player (position, pending read, pulse times) compared every cycle, plus
// hand-computed checkpoints and a randomized walk over a random maze.
module tb_maze_player_controller;

   localparam int W = 10;
   localparam int H = 10;
   localparam int L = 2;
   localparam logic [3:0] D_UP = 4'b0001;
   localparam logic [3:0] D_DN = 4'b0010;
   localparam logic [3:0] D_RT = 4'b0100;
   localparam logic [3:0] D_LT = 4'b1000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  player_direction = 4'b0000;
   logic        at_start = 1'b0;
   logic        maze_read_data = 1'b0;
   logic [10:0] maze_read_address;
   logic        maze_read_request;
   logic [7:0]  player_x, player_y;
   logic        at_end, move_blocked;
   logic [15:0] move_count;

   maze_player_controller #(
      .WIDTH        (W),
      .HEIGHT       (H),
      .ADDR_W       (11),
      .READ_LATENCY (L)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .player_direction  (player_direction),
      .at_start          (at_start),
      .maze_read_data    (maze_read_data),
      .maze_read_address (maze_read_address),
      .maze_read_request (maze_read_request),
      .player_x          (player_x),
      .player_y          (player_y),
      .at_end            (at_end),
      .move_blocked      (move_blocked),
      .move_count        (move_count)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   bit   maze [0:W*H-1];
   bit   filler_floor = 1'b0;

   // reference model state
   int       t = 0;
   int       m_x, m_y, m_cnt, m_addr;
   bit       m_end;
   logic [3:0] m_prev;
   bit       pend;
   int       p_tx, p_ty, p_dec, req_at, blk_at;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, t);
      end
   endtask

   task automatic model_reset();
      m_x = 0; m_y = 0; m_cnt = 0; m_addr = 0; m_end = 0;
      m_prev = 4'b0000; pend = 0; req_at = -1; blk_at = -1; p_dec = -1;
   endtask

   task automatic check_cycle();
      chk("read_request", maze_read_request, 32'(pend && (t == req_at)));
      chk("read_address", maze_read_address, m_addr);
      chk("player_x", player_x, m_x);
      chk("player_y", player_y, m_y);
      chk("at_end", at_end, m_end);
      chk("move_blocked", move_blocked, 32'(t == blk_at));
      chk("move_count", move_count, m_cnt);
   endtask

   // One clock cycle: compare outputs, drive inputs, advance the model.
   task automatic cyc(input logic [3:0] d, input bit st);
      int tx, ty;
      check_cycle();
      player_direction = d;
      at_start = st;
      if (pend && (t == p_dec)) maze_read_data = maze[p_ty*W + p_tx];
      else if (filler_floor)    maze_read_data = 1'b0;
      else                      maze_read_data = 1'($urandom);
      if (st) begin
         m_x = 0; m_y = 0; m_cnt = 0; m_end = 0; pend = 0;
      end else if (pend && (t == p_dec)) begin
         pend = 0;
         if (maze_read_data == 1'b0) begin
            m_x = p_tx; m_y = p_ty;
            if (m_cnt < 65535) m_cnt++;
            if ((m_x == W-1) && (m_y == H-1)) m_end = 1;
         end else begin
            blk_at = t + 1;
         end
      end else if (!pend && !m_end && ($countones(d) == 1) && (d != m_prev)) begin
         tx = m_x; ty = m_y;
         if (d == D_UP) ty--;
         else if (d == D_DN) ty++;
         else if (d == D_RT) tx++;
         else tx--;
         if ((tx < 0) || (tx >= W) || (ty < 0) || (ty >= H)) begin
            blk_at = t + 1;
         end else begin
            pend = 1; p_tx = tx; p_ty = ty;
            req_at = t + 1; p_dec = t + 1 + L;
            m_addr = ty*W + tx;
         end
      end
      m_prev = d;
      t++;
      @(negedge clock);
   endtask

   task automatic reset_values();
      chk("reset request", maze_read_request, 0);
      chk("reset address", maze_read_address, 0);
      chk("reset x", player_x, 0);
      chk("reset y", player_y, 0);
      chk("reset at_end", at_end, 0);
      chk("reset blocked", move_blocked, 0);
      chk("reset count", move_count, 0);
   endtask

   initial begin
      logic [3:0] cur;
      int r;
      for (int i = 0; i < W*H; i++) maze[i] = 1'b0;
      model_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_values();
      reset_n = 1'b1;

      // first move RIGHT onto tile 1
      cyc(D_RT, 0);
      chk("pin request after edge", maze_read_request, 1);
      chk("pin address after edge", maze_read_address, 1);
      cyc(D_RT, 0); cyc(D_RT, 0); cyc(D_RT, 0);
      chk("pin x at edge+4", player_x, 1);
      chk("pin count after first move", move_count, 1);
      cyc(4'b0000, 0); cyc(4'b0000, 1); cyc(4'b0000, 0);

      // boundary bumps at (0,0)
      cyc(D_UP, 0);
      chk("pin blocked on UP", move_blocked, 1);
      chk("pin no read on UP", maze_read_request, 0);
      cyc(4'b0000, 0);
      cyc(D_LT, 0);
      chk("pin blocked on LEFT", move_blocked, 1);
      cyc(4'b0000, 0);
      chk("pin x after bumps", player_x, 0);
      chk("pin y after bumps", player_y, 0);

      // holding DOWN gives a single move
      repeat (50) cyc(D_DN, 0);
      chk("pin y after held DOWN", player_y, 1);
      chk("pin count after held DOWN", move_count, 1);

      // DOWN into a wall
      cyc(4'b0000, 1);
      maze[10] = 1'b1;
      repeat (20) cyc(D_DN, 0);
      chk("pin y after wall", player_y, 0);
      chk("pin count after wall", move_count, 0);
      maze[10] = 1'b0;
      cyc(4'b0000, 0);

      // walk to the goal, then further presses are ignored
      for (int i = 0; i < 9; i++) begin cyc(D_RT, 0); repeat (5) cyc(4'b0000, 0); end
      for (int i = 0; i < 9; i++) begin cyc(D_DN, 0); repeat (5) cyc(4'b0000, 0); end
      chk("pin at_end on goal", at_end, 1);
      chk("pin count on goal", move_count, 18);
      cyc(D_UP, 0); repeat (5) cyc(4'b0000, 0);
      cyc(D_LT, 0); repeat (5) cyc(4'b0000, 0);
      chk("pin at_end held", at_end, 1);
      chk("pin x held on goal", player_x, 9);
      cyc(4'b0000, 1);
      chk("pin at_end after restart", at_end, 0);
      chk("pin x after restart", player_x, 0);
      chk("pin count after restart", move_count, 0);

      // restart while the read is in flight; stale data would be FLOOR
      filler_floor = 1'b1;
      cyc(D_RT, 0); cyc(4'b0000, 0); cyc(4'b0000, 1);
      repeat (6) cyc(4'b0000, 0);
      chk("pin x after abandoned read", player_x, 0);
      chk("pin count after abandoned read", move_count, 0);
      filler_floor = 1'b0;

      // asynchronous reset in the middle of a read
      cyc(D_RT, 0); repeat (4) cyc(4'b0000, 0);
      cyc(D_DN, 0); cyc(4'b0000, 0);
      #1 reset_n = 1'b0;
      #1 reset_values();
      @(negedge clock);
      @(negedge clock);
      model_reset();
      reset_n = 1'b1;
      cyc(4'b0000, 0);

      // randomized play over a random maze
      for (int i = 0; i < W*H; i++) maze[i] = ($urandom_range(0, 99) < 25);
      maze[0] = 1'b0;
      maze[W*H-1] = 1'b0;
      cur = 4'b0000;
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 7);
         if (r < 4)       cur = 4'b0001 << r;
         else if (r == 4) cur = 4'b0000;
         else if (r == 5) cur = 4'($urandom);
         cyc(cur, $urandom_range(0, 99) < 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/maze_player_controller.md
Name: maze_player_controller

Overview:
- Parametrised successor to the current player-movement block.
- Takes one-hot direction requests, reads the target tile from the maze RAM, and moves the player if the tile is FLOOR.
- Adds programmable start/end tiles, a parametrised RAM read latency, a wall-bump pulse, a saturating move counter and a latched finish state.
- Sits between the input debouncer and the maze RAM/renderer.

Parameters:
- WIDTH, 10, maze columns (2..255).
- HEIGHT, 10, maze rows (2..255).
- ADDR_W, 11, maze RAM address width; WIDTH*HEIGHT must be <= 2^ADDR_W.
- READ_LATENCY, 2, cycles from read-request cycle to valid maze_read_data (1..7).
- START_X, 0, reset/restart column.
- START_Y, 0, reset/restart row.
- END_X, WIDTH-1, goal column.
- END_Y, HEIGHT-1, goal row.
- REPEAT_PERIOD, 16, auto-repeat interval in cycles; used only with MAZE_AUTO_REPEAT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- player_direction  in  4  one-hot direction: UP=0001, DOWN=0010, RIGHT=0100, LEFT=1000.
- at_start  in  1  synchronous restart, level-sensitive.
- maze_read_data  in  1  tile at the requested address: 0=FLOOR, 1=WALL.
- maze_read_address  out  ADDR_W  target tile address, WIDTH*y + x.
- maze_read_request  out  1  one-cycle read strobe.
- player_x  out  8  current column.
- player_y  out  8  current row.
- at_end  out  1  high while the player sits on the goal; held until restart.
- move_blocked  out  1  one-cycle pulse on a wall or boundary bump.
- move_count  out  16  successful moves since restart; saturates at 16'hFFFF.

Behaviour:
Reset (reset_n low, asynchronous):
- state=IDLE; player_x=START_X; player_y=START_Y.
- at_end=0; move_blocked=0; maze_read_request=0; maze_read_address=0; move_count=0; prev_dir=0.

Direction sampling:
- prev_dir <= player_direction every cycle.
- A request is accepted only in IDLE, only when player_direction != prev_dir and player_direction is exactly one-hot.
- Zero or multi-bit values are ignored. Holding a key produces one move only.

Boundary:
- UP at y=0, DOWN at y=HEIGHT-1, LEFT at x=0, RIGHT at x=WIDTH-1: no read issued.
- move_blocked pulses the next cycle; state stays IDLE.

State machine (IDLE, REQ, WAIT, CHECK, DONE):
- IDLE: on an accepted in-bounds request, register target x/y and address (computed at ADDR_W width, no truncation), then go to REQ.
- REQ: maze_read_request=1 for exactly this cycle; load the wait counter with READ_LATENCY-1; go to WAIT, or straight to CHECK if READ_LATENCY=1.
- WAIT: decrement the counter; go to CHECK when it reaches 0.
- CHECK: sample maze_read_data.
  - FLOOR: commit target x/y and increment move_count (saturating). If the target equals (END_X, END_Y), go to DONE; otherwise go to IDLE.
  - WALL: pulse move_blocked; go to IDLE.
- DONE: at_end=1. All direction input is ignored. Stay until at_start.

Timing:
- Direction edge sampled in cycle N.
- Read strobe in N+1; data sampled in N+1+READ_LATENCY.
- New position visible in N+2+READ_LATENCY.

Restart:
- at_start=1 has highest priority in every state.
- Position returns to START; at_end=0; move_count=0; state=IDLE.
- Any in-flight read is abandoned and its data is never sampled.

Start equals end:
- If START equals END, at_end stays 0 until a move lands on the goal.

Optional Feature:
MAZE_AUTO_REPEAT_EN
- Defined: while the same one-hot direction is held in IDLE, a repeat timer re-accepts it every REPEAT_PERIOD cycles after the previous move completes. The timer clears on any direction change or restart.
- Undefined: edge-only acceptance as above; REPEAT_PERIOD is unused and no timer logic is generated.

Decomposition:
- maze_pkg holds:
  - direction one-hot constants UP, DOWN, RIGHT, LEFT;
  - tile constants FLOOR, WALL;
  - the state encoding (IDLE, REQ, WAIT, CHECK, DONE);
  - the one-hot check function.
- Sub-module maze_direction_sampler contains prev_dir, edge/one-hot qualification and the optional repeat timer. It outputs a one-cycle dir_valid with dir_code.

Test Plan:
- Reset with WIDTH=HEIGHT=10 and READ_LATENCY=2, then pulse RIGHT with tile 1 = FLOOR:
  - maze_read_request high in the cycle after the edge, with address=1;
  - player_x=1 at edge+4;
  - move_count=1.
- From (0,0), press UP and then LEFT: no maze_read_request; move_blocked pulses once per press; position stays (0,0).
- Hold DOWN for 50 cycles with tile 10 = FLOOR: exactly one move to (0,1).
- Hold DOWN for 50 cycles with MAZE_AUTO_REPEAT_EN and REPEAT_PERIOD=16: one move roughly every 16 cycles after each completed move.
- Hold DOWN where the target tile is WALL: move_blocked pulses once; move_count unchanged.
- Walk a FLOOR path to (9,9): at_end=1 and held while further presses are ignored; at_start then gives (0,0), at_end=0, move_count=0.
- Assert reset_n=0 during WAIT: outputs return to reset values immediately (no clock edge needed). Also assert at_start during WAIT with READ_LATENCY=5: no position change from the stale read.
